// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX/RX FSM state codes, counter width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // State codes kept as plain vectors so legacy RX/TX code can share them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Bits needed to hold value-1; for a baud divider this is the counter width.
  function automatic int uart_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter; bit_tick is high while the count sits at zero.
// Latency: a load of N gives bit_tick N cycles later; counter parks at zero, never wraps.
// Backpressure: none; load always wins over the decrement.
// Ports: clk, rst (async, active-high), load/load_val (reload strobe and value), bit_tick (out).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 868,
  localparam int CNT_W = uart_clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining the debug FIFO read port onto UART_TX (8 data bits, optional parity, 1-2 stop).
// Latency: start bit appears 1 cycle after the pop; frame period 1 + CLK_DIV*(9 + PARITY_EN + STOP_BITS).
// Backpressure: pops only in IDLE when TX_ENA=1 and the FIFO is non-empty; a started frame always completes.
// Ports: CLK, RST (async, active-high), TX_ENA, FIFO_RD_EMPTY/FIFO_RD_DATA (in), FIFO_RD_ENA, UART_TX, TX_BUSY (out).
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_ENA,
  input  logic       FIFO_RD_EMPTY,
  input  logic [7:0] FIFO_RD_DATA,
  output logic       FIFO_RD_ENA,
  output logic       UART_TX,
  output logic       TX_BUSY
);

  localparam int               CNT_W     = uart_clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLK_DIV - 1);

  logic [2:0] state_q,   state_d;
  logic [7:0] shift_q,   shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       parity_q,  parity_d;
  logic       uart_tx_q, uart_tx_d;
  logic       baud_load;
  logic       bit_tick;
  logic       pop;

  // Reset gates the strobe so no word is consumed while the block is held in reset.
  assign pop = !RST && (state_q == ST_IDLE) && TX_ENA && !FIFO_RD_EMPTY;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (CLK),
    .rst      (RST),
    .load     (baud_load),
    .load_val (BAUD_LOAD),
    .bit_tick (bit_tick)
  );

  // uart_tx_d is the value for the next state/bit, so the line is a clean flop output.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    uart_tx_d = uart_tx_q;
    baud_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        uart_tx_d = 1'b1;
        if (pop) begin
          shift_d   = FIFO_RD_DATA;
          parity_d  = (^FIFO_RD_DATA) ^ (PARITY_ODD != 0);
          bit_cnt_d = '0;
          state_d   = ST_START;
          uart_tx_d = 1'b0;
          baud_load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          uart_tx_d = shift_q[0];
          baud_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          baud_load = 1'b1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
            // bit_cnt wraps to 0 here and is reused to count stop bits.
            if (PARITY_EN != 0) begin
              state_d   = ST_PARITY;
              uart_tx_d = parity_q;
            end else begin
              state_d   = ST_STOP;
              uart_tx_d = 1'b1;
            end
          end else begin
            uart_tx_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d   = ST_STOP;
          uart_tx_d = 1'b1;
          baud_load = 1'b1;
        end
      end
      ST_STOP: begin
        uart_tx_d = 1'b1;
        if (bit_tick) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            baud_load = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        uart_tx_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  assign FIFO_RD_ENA = pop;
  assign UART_TX     = uart_tx_q;
  assign TX_BUSY     = (state_q != ST_IDLE) || pop;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: three instances (CLK_DIV=4 8N1, CLK_DIV=2 8N1, CLK_DIV=3 odd parity 2 stop).
// Each instance reads from a bench-owned FIFO; a frame-level model predicts pop/line/busy every cycle.
module tb_uart_fifo_tx;

  localparam int NI = 3;
  localparam int HN = 8192;

  function automatic int cd(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 3;
    endcase
  endfunction
  function automatic int pen(input int k);  return (k == 2) ? 1 : 0; endfunction
  function automatic int podd(input int k); return (k == 2) ? 1 : 0; endfunction
  function automatic int sb(input int k);   return (k == 2) ? 2 : 1; endfunction
  function automatic int nbits(input int k); return 10 + pen(k) + sb(k) - 1; endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] tx_ena;
  logic [NI-1:0] rd_empty;
  logic [NI-1:0] rd_ena;
  logic [NI-1:0] uart_tx;
  logic [NI-1:0] tx_busy;
  logic [7:0]    rd_data [NI];

  logic [7:0] mem [NI][64];
  int         wr_ptr [NI];
  int         rd_ptr [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign rd_empty[g] = (wr_ptr[g] == rd_ptr[g]);
    assign rd_data[g]  = mem[g][rd_ptr[g] % 64];
    uart_fifo_tx #(
      .CLK_DIV    (cd(g)),
      .PARITY_EN  (pen(g)),
      .PARITY_ODD (podd(g)),
      .STOP_BITS  (sb(g))
    ) u_dut (
      .CLK           (clk),
      .RST           (rst),
      .TX_ENA        (tx_ena[g]),
      .FIFO_RD_EMPTY (rd_empty[g]),
      .FIFO_RD_DATA  (rd_data[g]),
      .FIFO_RD_ENA   (rd_ena[g]),
      .UART_TX       (uart_tx[g]),
      .TX_BUSY       (tx_busy[g])
    );
  end

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Line level of frame slot 'slot' (start, D0..D7, optional parity, stops).
  function automatic logic slot_bit(input int k, input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (pen(k) != 0 && slot == 9) return (^b) ^ (podd(k) != 0);
    return 1'b1;
  endfunction

  // Observations and model state
  int         pop_cnt [NI];
  int         last_pop [NI];
  int         busy_run [NI];
  int         busy_len [NI];
  bit         pop_seen [NI];
  logic       hist [NI][HN];
  bit         m_busy [NI];
  int         m_pop [NI];
  logic [7:0] m_byte [NI];
  int         m_rd [NI];
  logic       e_pop, e_tx, e_busy;
  int         e_idx;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        e_pop = 1'b0; e_tx = 1'b1; e_busy = 1'b0;
      end else if (m_busy[k]) begin
        e_idx  = cyc - m_pop[k];
        e_pop  = 1'b0;
        e_busy = 1'b1;
        e_tx   = slot_bit(k, m_byte[k], (e_idx - 1) / cd(k));
        if (e_idx >= cd(k) * nbits(k)) m_busy[k] = 1'b0;
      end else begin
        e_pop  = tx_ena[k] && (m_rd[k] != wr_ptr[k]);
        e_tx   = 1'b1;
        e_busy = e_pop;
        if (e_pop) begin
          m_byte[k] = mem[k][m_rd[k] % 64];
          m_rd[k]++;
          m_busy[k] = 1'b1;
          m_pop[k]  = cyc;
        end
      end
      chk($sformatf("dut%0d_pop_tx_busy", k), {29'd0, rd_ena[k], uart_tx[k], tx_busy[k]},
          {29'd0, e_pop, e_tx, e_busy});
      pop_seen[k] = rd_ena[k];
      if (rd_ena[k]) begin
        pop_cnt[k]++;
        last_pop[k] = cyc;
      end
      if (tx_busy[k]) busy_run[k]++;
      else if (busy_run[k] != 0) begin
        busy_len[k] = busy_run[k];
        busy_run[k] = 0;
      end
      hist[k][cyc % HN] = uart_tx[k];
    end
    cyc++;
  end

  // FIFO read side advances just after the edge on which the strobe was high.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) if (pop_seen[k]) rd_ptr[k]++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_ptr[k] % 64] = b;
    wr_ptr[k]++;
  endtask

  task automatic wait_pop(input int k, output int p);
    int start;
    int budget;
    start  = pop_cnt[k];
    budget = 300;
    while (pop_cnt[k] == start && budget > 0) begin
      tick(1);
      budget--;
    end
    if (pop_cnt[k] == start) chk($sformatf("dut%0d_pop_timeout", k), 32'(pop_cnt[k] - start), 32'd1);
    p = last_pop[k];
  endtask

  task automatic chk_frame(input int k, input int p, input logic [15:0] exp, input int nslots,
                           input string nm);
    logic [15:0] obs;
    logic        stable;
    logic        b;
    obs    = '0;
    stable = 1'b1;
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < cd(k); c++) begin
        b = hist[k][(p + 1 + s * cd(k) + c) % HN];
        if (c == 0) obs[s] = b;
        else if (b !== obs[s]) stable = 1'b0;
      end
    end
    chk(nm, 32'(obs), 32'(exp));
    chk({nm, "_stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    int p, p1, p2, c, base, cnt;
    rst    = 1'b1;
    tx_ena = '1;
    tick(3);
    chk("reset_tx", 32'(uart_tx), 32'd7);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_pop", 32'(rd_ena), 32'd0);
    rst = 1'b0;

    // Idle with empty FIFO
    base = pop_cnt[0];
    c    = cyc;
    tick(100);
    cnt = 0;
    for (int i = c; i < cyc; i++) if (hist[0][i % HN] !== 1'b1) cnt++;
    chk("idle_tx_low_cycles", 32'(cnt), 32'd0);
    chk("idle_pops", 32'(pop_cnt[0] - base), 32'd0);
    chk("idle_busy_cycles", 32'(busy_run[0]), 32'd0);

    // Single byte 0x55, CLK_DIV=4
    base = pop_cnt[0];
    push(0, 8'h55);
    wait_pop(0, p);
    tick(50);
    chk("single_pops", 32'(pop_cnt[0] - base), 32'd1);
    chk_frame(0, p, 16'h2AA, 10, "single_frame_55");
    chk("single_busy_len", 32'(busy_len[0]), 32'd41);

    // Back-to-back 0x00, 0xFF, CLK_DIV=2
    push(1, 8'h00);
    push(1, 8'hFF);
    wait_pop(1, p1);
    wait_pop(1, p2);
    chk("b2b_pop_gap", 32'(p2 - p1), 32'd21);
    tick(30);
    chk_frame(1, p1, 16'h200, 10, "b2b_frame_00");
    chk_frame(1, p2, 16'h3FE, 10, "b2b_frame_ff");
    chk("b2b_busy_len", 32'(busy_len[1]), 32'd42);

    // Odd parity, 2 stop bits, 0x07, CLK_DIV=3
    push(2, 8'h07);
    push(2, 8'h07);
    wait_pop(2, p1);
    wait_pop(2, p2);
    chk("parity_frame_period", 32'(p2 - p1), 32'd37);
    tick(40);
    chk_frame(2, p1, 16'hC0E, 12, "parity_frame_07");
    chk("parity_bit", 32'(hist[2][(p1 + 29) % HN]), 32'd0);
    cnt = 0;
    for (int i = p1 + 31; i <= p1 + 36; i++) if (hist[2][i % HN] === 1'b1) cnt++;
    chk("stop_high_cycles", 32'(cnt), 32'd6);

    // TX_ENA dropped during D3 with 3 bytes queued
    push(0, 8'h3C);
    push(0, 8'hC3);
    push(0, 8'h5A);
    base = pop_cnt[0];
    wait_pop(0, p);
    tick(17);
    tx_ena[0] = 1'b0;
    tick(60);
    chk("gate_pops", 32'(pop_cnt[0] - base), 32'd1);
    chk("gate_fifo_not_empty", 32'(rd_empty[0]), 32'd0);
    chk("gate_busy_after", 32'(tx_busy[0]), 32'd0);
    chk_frame(0, p, 16'h278, 10, "gate_frame_3c");
    c = cyc;
    tx_ena[0] = 1'b1;
    wait_pop(0, p);
    chk("reenable_pop_cycle", 32'(p - c), 32'd0);
    tick(100);

    // Asynchronous reset during D5
    push(0, 8'h0F);
    push(0, 8'hA3);
    wait_pop(0, p);
    tick(25);
    chk("pre_reset_tx_d5", 32'(uart_tx[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(uart_tx[0]), 32'd1);
    chk("rst_async_busy", 32'(tx_busy[0]), 32'd0);
    tick(2);
    rst  = 1'b0;
    base = pop_cnt[0];
    wait_pop(0, p);
    tick(50);
    chk_frame(0, p, 16'h346, 10, "post_reset_frame_a3");
    chk("post_reset_pops", 32'(pop_cnt[0] - base), 32'd1);
    chk("post_reset_fifo_empty", 32'(rd_empty[0]), 32'd1);

    // Randomized traffic and enable toggling, checked by the per-cycle model
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 39) == 0 && (wr_ptr[k] - rd_ptr[k]) < 6) push(k, 8'($urandom));
        if ($urandom_range(0, 299) == 0) tx_ena[k] = ~tx_ena[k];
      end
      tick(1);
    end
    tx_ena = '1;
    tick(400);
    for (int k = 0; k < NI; k++)
      chk($sformatf("dut%0d_drained", k), 32'(rd_empty[k]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
